// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-port priority, optional
// same-cycle write-to-read bypass and a per-register pending (scoreboard) bit.
// Register 0 is hardwired to zero and is never pending.
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int BYPASS    = 1,
    localparam int ADDR_W   = $clog2(REG_COUNT)
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_pending_o,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
    input  logic                       alloc_en_i,
    input  logic [ADDR_W-1:0]          alloc_addr_i,
    output logic                       any_pending_o
);

    // Entry 0 is reset like the others but never written, so it stays zero
    // and folds away in synthesis.
    logic [DATA_W-1:0]    data_reg [REG_COUNT];
    logic [REG_COUNT-1:0] pend_reg;

    // Per-register decoded write request (winning port data) and alloc request.
    logic [REG_COUNT-1:0] wr_hit;
    logic [DATA_W-1:0]    wr_val [REG_COUNT];
    logic [REG_COUNT-1:0] alloc_hit;

    // Decode write ports per register; later (higher-index) ports override
    // earlier ones, giving the highest-index port priority.
    always_comb begin
        wr_hit    = '0;
        alloc_hit = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            wr_val[r] = '0;
        end
        for (int r = 1; r < REG_COUNT; r++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data_i[w*DATA_W +: DATA_W];
                end
            end
            alloc_hit[r] = alloc_en_i && (alloc_addr_i == ADDR_W'(r));
        end
    end

    // State update: writes land data and clear pending; an alloc in the same
    // cycle re-sets pending because the new producer supersedes the old one.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                data_reg[r] <= '0;
            end
            pend_reg <= '0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (wr_hit[r]) begin
                    data_reg[r] <= wr_val[r];
                end
            end
            pend_reg <= alloc_hit | (pend_reg & ~wr_hit);
        end
    end

    // Drain status from registered pending bits only.
    assign any_pending_o = |pend_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;
            logic              pend;

            assign addr = rd_addr_i[gi*ADDR_W +: ADDR_W];

            // Combinational read; outputs are forced to zero while in reset so
            // a write presented during reset cannot leak through the bypass.
            always_comb begin
                data = '0;
                pend = 1'b0;
                if (rstn_i && (addr != '0)) begin
                    if ((BYPASS != 0) && wr_hit[addr]) begin
                        data = wr_val[addr];
                        pend = 1'b0;
                    end else begin
                        data = data_reg[addr];
                        pend = pend_reg[addr];
                    end
                end
            end

            assign rd_data_o[gi*DATA_W +: DATA_W] = data;
            assign rd_pending_o[gi]               = pend;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one bypassing and one non-bypassing
// instance share stimulus; expected read results come from an array model.
module tb_regfile_mp;

    localparam int DW = 64;
    localparam int RC = 16;
    localparam int AW = 4;
    localparam int NR = 3;
    localparam int NW = 2;

    typedef struct packed {
        logic             rst_n;
        logic [NW-1:0]    we;
        logic [NW*AW-1:0] wa;
        logic [NW*DW-1:0] wd;
        logic             al;
        logic [AW-1:0]    aa;
        logic [NR*AW-1:0] ra;
    } stim_t;

    typedef struct {
        int               cyc;
        logic [NR*DW-1:0] d_b;
        logic [NR*DW-1:0] d_n;
        logic [NR-1:0]    p_b;
        logic [NR-1:0]    p_n;
        logic             any;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NW-1:0]    wr_en = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*DW-1:0] wr_data = '0;
    logic             alloc_en = 1'b0;
    logic [AW-1:0]    alloc_addr = '0;

    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_pend_b, rd_pend_n;
    logic             any_b, any_n;

    int tests = 0;
    int fails = 0;
    int cyc_no = 0;
    exp_t q[$];

    logic [DW-1:0] m_data [RC];
    logic          m_pend [RC];

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .REG_COUNT(RC), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .rd_pending_o(rd_pend_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .any_pending_o(any_b)
    );

    regfile_mp #(.DATA_W(DW), .REG_COUNT(RC), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_n (
        .clk_i(clk), .rstn_i(rstn), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n),
        .rd_pending_o(rd_pend_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .any_pending_o(any_n)
    );

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    // Drive one cycle's inputs, predict the reads from the model state, queue
    // the prediction, then advance the model across the coming edge.
    task automatic step(input stim_t s);
        exp_t          e;
        logic [DW-1:0] v;
        logic          hit;
        int            a;
        @(posedge clk);
        #1;
        rstn       = s.rst_n;
        wr_en      = s.we;
        wr_addr    = s.wa;
        wr_data    = s.wd;
        alloc_en   = s.al;
        alloc_addr = s.aa;
        rd_addr    = s.ra;
        e.cyc = cyc_no;
        cyc_no++;
        e.d_b = '0;
        e.d_n = '0;
        e.p_b = '0;
        e.p_n = '0;
        e.any = 1'b0;
        if (s.rst_n) begin
            for (int r = 0; r < RC; r++) e.any = e.any | m_pend[r];
            for (int k = 0; k < NR; k++) begin
                a = int'(s.ra[k*AW +: AW]);
                if (a != 0) begin
                    hit = 1'b0;
                    v   = '0;
                    for (int w = 0; w < NW; w++) begin
                        if (s.we[w] && int'(s.wa[w*AW +: AW]) == a) begin
                            hit = 1'b1;
                            v   = s.wd[w*DW +: DW];
                        end
                    end
                    e.d_n[k*DW +: DW] = m_data[a];
                    e.p_n[k]          = m_pend[a];
                    e.d_b[k*DW +: DW] = hit ? v : m_data[a];
                    e.p_b[k]          = hit ? 1'b0 : m_pend[a];
                end
            end
        end
        q.push_back(e);
        if (!s.rst_n) begin
            for (int r = 0; r < RC; r++) begin
                m_data[r] = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            for (int w = 0; w < NW; w++) begin
                a = int'(s.wa[w*AW +: AW]);
                if (s.we[w] && a != 0) begin
                    m_data[a] = s.wd[w*DW +: DW];
                    m_pend[a] = 1'b0;
                end
            end
            a = int'(s.aa);
            if (s.al && a != 0) m_pend[a] = 1'b1;
        end
    endtask

    function automatic void check(input string nm, input int cyc, input logic [DW-1:0] act,
                                  input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc %0d: got %h, expected %h", nm, cyc, act, req);
        end
    endfunction

    // Monitor: outputs are combinational, so every cycle presents a result;
    // sample on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < NR; k++) begin
                    check($sformatf("byp_data%0d", k), e.cyc, rd_data_b[k*DW +: DW], e.d_b[k*DW +: DW]);
                    check($sformatf("nob_data%0d", k), e.cyc, rd_data_n[k*DW +: DW], e.d_n[k*DW +: DW]);
                    check($sformatf("byp_pend%0d", k), e.cyc, DW'(rd_pend_b[k]), DW'(e.p_b[k]));
                    check($sformatf("nob_pend%0d", k), e.cyc, DW'(rd_pend_n[k]), DW'(e.p_n[k]));
                end
                check("byp_any", e.cyc, DW'(any_b), DW'(e.any));
                check("nob_any", e.cyc, DW'(any_n), DW'(e.any));
                $display("[TB] cyc %0d rd0=%h rd1=%h rd2=%h pend=%b any=%b", e.cyc,
                         rd_data_b[0 +: DW], rd_data_b[DW +: DW], rd_data_b[2*DW +: DW],
                         rd_pend_b, any_b);
            end
        end
    end

    initial begin
        stim_t s;
        for (int r = 0; r < RC; r++) begin
            m_data[r] = '0;
            m_pend[r] = 1'b0;
        end

        // Reset, then sweep every address across all read ports.
        s = idle(); s.rst_n = 1'b0; step(s);
        for (int a = 0; a < RC; a++) begin
            s = idle();
            s.ra[0 +: AW]    = AW'(a);
            s.ra[AW +: AW]   = AW'((a + 1) % RC);
            s.ra[2*AW +: AW] = AW'((a + 5) % RC);
            step(s);
        end

        // Write x5, read it back, then assert reset mid-run with a write in flight.
        s = idle(); s.we = 2'b01; s.wa[0 +: AW] = 4'd5; s.wd[0 +: DW] = 64'hDEADBEEF; step(s);
        s = idle(); s.ra[0 +: AW] = 4'd5; step(s);
        s = idle(); s.rst_n = 1'b0; s.ra[0 +: AW] = 4'd5; s.ra[AW +: AW] = 4'd5;
        s.we = 2'b10; s.wa[AW +: AW] = 4'd5; s.wd[DW +: DW] = 64'h1; s.al = 1'b1; s.aa = 4'd5; step(s);
        s = idle(); s.ra[0 +: AW] = 4'd5; step(s);

        // Top register and register 0 written in the same cycle.
        s = idle(); s.we = 2'b11;
        s.wa[0 +: AW] = 4'd15; s.wd[0 +: DW] = 64'h12345678;
        s.wa[AW +: AW] = 4'd0; s.wd[DW +: DW] = '1;
        s.ra[2*AW +: AW] = 4'd0; step(s);
        s = idle(); s.ra[0 +: AW] = 4'd15; s.ra[AW +: AW] = 4'd0; step(s);

        // Same-cycle write/read of x7: bypass vs registered view.
        s = idle(); s.we = 2'b01; s.wa[0 +: AW] = 4'd7; s.wd[0 +: DW] = 64'hA5A5A5A5;
        s.ra[AW +: AW] = 4'd7; step(s);
        s = idle(); s.ra[AW +: AW] = 4'd7; step(s);

        // Two ports write x3 together: highest index wins.
        s = idle(); s.we = 2'b11;
        s.wa[0 +: AW] = 4'd3; s.wd[0 +: DW] = 64'h1111;
        s.wa[AW +: AW] = 4'd3; s.wd[DW +: DW] = 64'h2222;
        s.ra[0 +: AW] = 4'd3; step(s);
        s = idle(); s.ra[0 +: AW] = 4'd3; s.ra[2*AW +: AW] = 4'd3; step(s);

        // Pending scoreboard on x9.
        s = idle(); s.al = 1'b1; s.aa = 4'd9; s.ra[0 +: AW] = 4'd9; step(s);
        s = idle(); s.ra[0 +: AW] = 4'd9; step(s);
        s = idle(); s.we = 2'b01; s.wa[0 +: AW] = 4'd9; s.wd[0 +: DW] = 64'h55;
        s.ra[0 +: AW] = 4'd9; step(s);
        s = idle(); s.ra[0 +: AW] = 4'd9; step(s);
        s = idle(); s.al = 1'b1; s.aa = 4'd9; s.we = 2'b10; s.wa[AW +: AW] = 4'd9;
        s.wd[DW +: DW] = 64'h66; s.ra[0 +: AW] = 4'd9; step(s);
        s = idle(); s.ra[0 +: AW] = 4'd9; s.ra[AW +: AW] = 4'd9; step(s);
        s = idle(); s.al = 1'b1; s.aa = 4'd0; step(s);
        s = idle(); s.ra[0 +: AW] = 4'd0; s.ra[AW +: AW] = 4'd9; step(s);

        // Randomised traffic with occasional mid-run resets.
        for (int i = 0; i < 2000; i++) begin
            s = idle();
            s.rst_n = ($urandom_range(0, 199) != 0);
            for (int w = 0; w < NW; w++) begin
                s.we[w]            = 1'($urandom_range(0, 1));
                s.wa[w*AW +: AW]   = AW'($urandom_range(0, RC - 1));
                s.wd[w*DW +: DW]   = {$urandom, $urandom};
            end
            s.al = ($urandom_range(0, 3) == 0);
            s.aa = AW'($urandom_range(0, RC - 1));
            for (int k = 0; k < NR; k++) begin
                case ($urandom_range(0, 3))
                    0:       s.ra[k*AW +: AW] = s.wa[0 +: AW];
                    1:       s.ra[k*AW +: AW] = s.wa[AW +: AW];
                    2:       s.ra[k*AW +: AW] = s.aa;
                    default: s.ra[k*AW +: AW] = AW'($urandom_range(0, RC - 1));
                endcase
            end
            step(s);
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file with write-port prioritisation, optional same-cycle write-to-read bypass and a per-register pending (scoreboard) bit. It sits in decode alongside the hazard logic. Decode reads operands and pending status, issue allocates destination registers, and writeback ports write results and clear pending. Register 0 is hardwired to zero and is never pending.

Parameters:
DATA_W, 32, register data width in bits
REG_COUNT, 32, number of architectural registers (≥2, power of two)
ADDR_W, $clog2(REG_COUNT), register address width (derived, not overridden)
NUM_RD, 2, number of combinational read ports
NUM_WR, 1, number of write (writeback) ports
BYPASS, 1, 1 = read port returns same-cycle write data; 0 = read returns registered state only

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  asynchronous active-low reset
rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_pending_o  out  NUM_RD  1 = register read by port k awaits a writeback
wr_en_i  in  NUM_WR  write enable per write port
wr_addr_i  in  NUM_WR*ADDR_W  write addresses
wr_data_i  in  NUM_WR*DATA_W  write data
alloc_en_i  in  1  mark alloc_addr_i pending (issue of a producer)
alloc_addr_i  in  ADDR_W  register to mark pending
any_pending_o  out  1  OR of all pending bits (drain/flush status)

Behaviour:
- State: REG_COUNT x DATA_W data array plus REG_COUNT pending bits. Entry 0 is not stored; it reads 0 and pending 0.
- Async reset (rstn_i low): all data = 0, all pending = 0, independent of clk_i. Outputs during reset: rd_data_o = 0, rd_pending_o = 0, any_pending_o = 0. Reset may assert mid-operation; all in-flight writes and allocations are discarded.
- Write: on the rising edge, for each port w with wr_en_i[w]=1 and wr_addr≠0, data[wr_addr] <= wr_data. All registers 1..REG_COUNT-1 are writable. Writes to address 0 are ignored.
- Write conflict: several enabled ports hitting the same address → the highest-index port wins, for both data and bypass.
- Pending clear: any enabled write to address a≠0 clears pending[a] at the edge.
- Pending set: alloc_en_i=1 with alloc_addr_i≠0 sets pending[alloc_addr_i] at the edge. Allocating a register that is already pending is legal; the bit stays 1, and no counting is done.
- Simultaneous alloc and write to the same address in one cycle: alloc wins. Data is written and pending ends at 1, because a new producer supersedes the completing one.
- Read, combinational, zero latency:
  - addr=0 → data 0, pending 0.
  - BYPASS=1 and some enabled write port matches addr → data = winning wr_data, pending = 0.
  - Otherwise → data = registered value, pending = registered pending bit.
  - Alloc in the same cycle never affects reads; it takes effect after the edge.
- BYPASS=0: reads see writes one cycle after the edge; pending reflects registered state only.
- any_pending_o is combinational from registered pending bits; no bypass.
- Read ports are independent; identical addresses on several ports return identical values.
- No X propagation from unused ports: wr_addr/wr_data are don't-care when wr_en=0.

Test Plan:
1. Reset, then read all addresses on both ports → data 0, pending 0, any_pending_o 0. Assert rstn_i low mid-run after writing x5=0xDEADBEEF → x5 reads 0 immediately, before any clock edge.
2. Write x31=0x12345678 (top register), x0=0xFFFFFFFF → next cycle x31 reads 0x12345678 and x0 reads 0.
3. BYPASS=1: same cycle wr x7=0xA5A5A5A5 with rd port1 addr 7 → rd_data 0xA5A5A5A5, pending 0 in that cycle. BYPASS=0 build → old value (0) in that cycle, new value next cycle.
4. NUM_WR=2: port0 writes x3=0x1111, port1 writes x3=0x2222 in the same cycle → x3 = 0x2222, and the bypass returns 0x2222.
5. Scoreboard: alloc x9 → next cycle rd_pending=1, any_pending_o=1. Write x9=0x55 → next cycle pending 0, any_pending_o 0. Alloc x9 and write x9=0x66 in the same cycle → data 0x66, pending 1. Alloc x0 → pending stays 0.
6. Randomised: 2000 cycles of random writes, allocs and reads against a reference model with parameters REG_COUNT=16, DATA_W=64, NUM_RD=3, NUM_WR=2 → zero mismatches.
